mdu: RTL
========

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameters: none; iteration count fixed at 32.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  operation request; sampled only when busy=0.
REQ-005 op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 A  input  32  multiplicand / dividend; captured with start.
REQ-007 B  input  32  multiplier / divisor; captured with start.
REQ-008 busy  output  1  operation in progress; start ignored while high.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 hi  output  32  MUL: product[63:32]; DIV: remainder.
REQ-011 lo  output  32  MUL: product[31:0]; DIV: quotient.
REQ-012 div_by_zero  output  1  one-cycle flag, coincident with done, DIV/DIVU with B=0 only.

Function
REQ-013 FSM states IDLE, RUN, FIX, DONE; reset state IDLE.
REQ-014 IDLE: start=1 at edge k latches op, A, B; next state RUN, iteration counter cleared to 0.
REQ-015 Signed ops latch |A|, |B| and record result signs; unsigned ops latch raw operands.
REQ-016 RUN: one shift-add (MUL) or restoring shift-subtract (DIV) step per cycle, counter 0..31; leaves RUN after the step with counter=31.
REQ-017 FIX: one cycle; applies two's-complement sign correction; next state DONE.
REQ-018 hi/lo written at entry to DONE (edge k+34); done=1 for exactly the cycle after edge k+34.
REQ-019 DONE -> IDLE unconditionally; start in the DONE cycle is ignored.
REQ-020 busy=1 in every cycle from edge k+1 through the DONE cycle inclusive; busy=0 in IDLE.
REQ-021 hi/lo hold their last written values until the next DONE; unchanged while busy.
REQ-022 MULT: 64-bit signed product; MULTU: 64-bit unsigned product; no overflow indication.
REQ-023 DIV: quotient truncated toward zero; remainder takes sign of dividend.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000, div_by_zero=0.
REQ-025 DIV/DIVU with B=0: IDLE -> DONE directly at edge k+1; lo=0xFFFFFFFF, hi=A; div_by_zero=1 with done.
REQ-026 Changes on A, B, op while busy have no effect on the in-flight result.

Reset
REQ-027 rst=1 forces immediately, independent of clk: state IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
REQ-028 rst asserted mid-operation aborts it; no done pulse; hi/lo read 0.
REQ-029 First start accepted on the first rising edge with rst=0.

Configuration
REQ-030 Macro MDU_SIGNED_EN: defined -> op[0] selects signed (MULT/DIV) per REQ-015..REQ-024.
REQ-031 MDU_SIGNED_EN undefined -> op[0] ignored, all ops unsigned, no sign/FIX logic; FIX still occupies one cycle so latency is unchanged.

Verification
REQ-032 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> done at edge k+34, hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 MULT A=0xFFFFFFFE(-2) B=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; DIV A=-7 B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 DIVU A=100 B=0 -> done and div_by_zero at edge k+1, lo=0xFFFFFFFF, hi=100, busy high one cycle.
REQ-035 DIVU A=100 B=7 started, second start with other operands at k+5 and in DONE cycle -> ignored; lo=14, hi=2, exactly one done.
REQ-036 rst pulsed asynchronously at k+10 of a MULTU -> busy=0, hi=lo=0 at once, no done; new MULTU 6*7 after release -> lo=42, hi=0.
REQ-037 Build without MDU_SIGNED_EN: op=01 A=0xFFFFFFFE B=3 -> hi=0x00000002, lo=0xFFFFFFFA (unsigned result), latency 34.

Source files
------------

// File: rtl/mdu_if.sv
// Handshake and result bus between an MDU requester (master) and the mdu (slave).
interface mdu_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    modport master (output start, op, A, B,
                    input  busy, done, hi, lo, div_by_zero);
    modport slave  (input  start, op, A, B,
                    output busy, done, hi, lo, div_by_zero);
endinterface

// File: rtl/mdu.sv
// Iterative 32-bit multiply/divide unit: 32 shift-add / restoring shift-subtract steps.
// Define MDU_SIGNED_EN to enable signed MULT/DIV (op[0]); otherwise all ops are unsigned.
module mdu (
    input  logic clk,
    input  logic rst,
    mdu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state, next_state;
    logic [4:0]  count;
    logic        is_div;
    logic [31:0] operand_b;
    logic [31:0] upper, lower;
    logic [31:0] hi_r, lo_r;
    logic        dbz;
    logic        accept, zero_div;
    logic [31:0] in_a, in_b;
    logic [31:0] fix_hi, fix_lo;
    logic [32:0] mul_sum, div_shift, div_diff;

    assign accept   = (state == IDLE) && bus.start;
    assign zero_div = bus.op[1] && (bus.B == 32'd0);

`ifdef MDU_SIGNED_EN
    logic        neg_lo, neg_hi;
    logic        in_neg_lo, in_neg_hi;
    logic [63:0] neg_prod;

    // Operate on magnitudes; remainder follows the dividend, quotient/product the xor of signs.
    assign in_a      = (bus.op[0] && bus.A[31]) ? -bus.A : bus.A;
    assign in_b      = (bus.op[0] && bus.B[31]) ? -bus.B : bus.B;
    assign in_neg_lo = bus.op[0] && (bus.A[31] ^ bus.B[31]);
    assign in_neg_hi = bus.op[0] && (bus.op[1] ? bus.A[31] : (bus.A[31] ^ bus.B[31]));
    assign neg_prod  = -{upper, lower};

    always_comb begin
        fix_hi = upper;
        fix_lo = lower;
        if (is_div) begin
            if (neg_hi) fix_hi = -upper;
            if (neg_lo) fix_lo = -lower;
        end else if (neg_lo) begin
            fix_hi = neg_prod[63:32];
            fix_lo = neg_prod[31:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
        end else if (accept) begin
            neg_lo <= in_neg_lo;
            neg_hi <= in_neg_hi;
        end
    end
`else
    assign in_a   = bus.A;
    assign in_b   = bus.B;
    assign fix_hi = upper;
    assign fix_lo = lower;
`endif

    // MUL keeps {acc, multiplier} in {upper, lower}; DIV keeps {remainder, dividend/quotient}.
    assign mul_sum   = {1'b0, upper} + {1'b0, (lower[0] ? operand_b : 32'd0)};
    assign div_shift = {upper, lower[31]};
    assign div_diff  = div_shift - {1'b0, operand_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = zero_div ? DONE : RUN;
            RUN:  if (count == 5'd31) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= 5'd0;
            is_div    <= 1'b0;
            operand_b <= 32'd0;
            upper     <= 32'd0;
            lower     <= 32'd0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            dbz       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    is_div    <= bus.op[1];
                    operand_b <= in_b;
                    count     <= 5'd0;
                    if (zero_div) begin
                        hi_r <= bus.A;
                        lo_r <= 32'hFFFF_FFFF;
                        dbz  <= 1'b1;
                    end else begin
                        upper <= 32'd0;
                        lower <= in_a;
                        dbz   <= 1'b0;
                    end
                end
                RUN: begin
                    count <= count + 5'd1;
                    if (!is_div) begin
                        upper <= mul_sum[32:1];
                        lower <= {mul_sum[0], lower[31:1]};
                    end else if (!div_diff[32]) begin
                        upper <= div_diff[31:0];
                        lower <= {lower[30:0], 1'b1};
                    end else begin
                        upper <= div_shift[31:0];
                        lower <= {lower[30:0], 1'b0};
                    end
                end
                FIX: begin
                    hi_r <= fix_hi;
                    lo_r <= fix_lo;
                end
                DONE: dbz <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
    assign bus.div_by_zero = dbz;
endmodule
